// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES-128 streaming wrapper.
// Holds the FSM state encoding and 32-bit word select/insert within a 128-bit block.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int AES_LATENCY   = 12;
    localparam int WORDS_PER_BLK = 4;

    // Word 0 is the most significant word of a block, matching the wire order.
    typedef logic [1:0] word_idx_t;

    function automatic logic [31:0] word_sel(input logic [127:0] blk, input word_idx_t idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [127:0] word_ins(input logic [127:0] blk, input word_idx_t idx,
                                              input logic [31:0] w);
        logic [127:0] r;
        r = blk;
        case (idx)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_word_ser.sv
// 128->32 serialiser: ld captures a block, first word valid the next cycle, 1 word/cycle.
// Backpressure: out_data/out_last hold while out_valid && !out_ready; done pulses on the 4th handshake.
module aes_word_ser
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [127:0] ld_dat,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         done
);

    logic [127:0] buf_q,       buf_d;
    word_idx_t    idx_q,       idx_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_data_q,  out_data_d;
    logic         out_last_q,  out_last_d;
    logic         xfer;

    always_comb begin
        buf_d       = buf_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        xfer        = out_valid_q & out_ready;
        done        = xfer & (idx_q == 2'd3);

        if (ld) begin
            buf_d       = ld_dat;
            idx_d       = 2'd0;
            out_valid_d = 1'b1;
            out_data_d  = word_sel(ld_dat, 2'd0);
            out_last_d  = 1'b0;
        end else if (xfer) begin
            if (idx_q == 2'd3) begin
                idx_d       = 2'd0;
                out_valid_d = 1'b0;
                out_data_d  = '0;
                out_last_d  = 1'b0;
            end else begin
                idx_d       = idx_q + 2'd1;
                out_data_d  = word_sel(buf_q, idx_q + 2'd1);
                out_last_d  = (idx_q == 2'd2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: rtl/aes_stream_ctrl.sv
// 32-bit streaming wrapper around an AES-128 core: packs 4 words, pulses load, drains ciphertext.
// Latency: ld 1 cycle after 4th input word, words out 1 cycle after core done; input stalls until drained.
module aes_stream_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter bit KEY_LOCK    = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         key_we,
    input  logic [1:0]   key_idx,
    input  logic [31:0]  key_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         aes_ld,
    output logic [127:0] aes_key,
    output logic [127:0] aes_text_in,
    input  logic         aes_done,
    input  logic [127:0] aes_text_out,
    output logic         busy,
    input  logic         err_clr,
    output logic         timeout_err,
    output logic         key_err
);

    localparam int WCW = $clog2(TIMEOUT_CYC + 1);

    state_t       state_q,       state_d;
    word_idx_t    wcnt_q,        wcnt_d;
    logic [WCW-1:0] wait_cnt_q,  wait_cnt_d;
    logic [127:0] blk_q,         blk_d;
    logic [127:0] key_q,         key_d;
    logic         in_ready_q,    in_ready_d;
    logic         aes_ld_q,      aes_ld_d;
    logic         busy_q,        busy_d;
    logic         timeout_err_q, timeout_err_d;
    logic         key_err_q,     key_err_d;

    logic in_xfer;
    logic key_ok;
    logic timeout_evt;
    logic key_evt;
    logic ser_ld;
    logic ser_done;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        wait_cnt_d  = wait_cnt_q;
        blk_d       = blk_q;
        key_d       = key_q;
        timeout_evt = 1'b0;
        key_evt     = 1'b0;
        ser_ld      = 1'b0;
        in_xfer     = in_valid & in_ready_q & (state_q == IDLE);
        key_ok      = !KEY_LOCK || (state_q == IDLE);

        if (key_we) begin
            if (key_ok) begin
                key_d = word_ins(key_q, word_idx_t'(key_idx), key_data);
            end else begin
                key_evt = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    blk_d  = {blk_q[95:0], in_data};
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == 2'd3) begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                state_d    = WAIT;
                wait_cnt_d = WCW'(1);
            end
            WAIT: begin
                // A done on the final allowed cycle still counts as success.
                if (aes_done) begin
                    ser_ld     = 1'b1;
                    state_d    = DRAIN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCW'(TIMEOUT_CYC)) begin
                    timeout_evt = 1'b1;
                    state_d     = IDLE;
                    wait_cnt_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            DRAIN: begin
                if (ser_done) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d    = (state_d == IDLE);
        aes_ld_d      = (state_d == LOAD);
        busy_d        = (state_d != IDLE) || (wcnt_d != 2'd0);
        // A fresh error in the same cycle as err_clr keeps the flag set.
        timeout_err_d = timeout_evt | (timeout_err_q & ~err_clr);
        key_err_d     = key_evt     | (key_err_q     & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            wcnt_q        <= '0;
            wait_cnt_q    <= '0;
            blk_q         <= '0;
            key_q         <= '0;
            in_ready_q    <= 1'b0;
            aes_ld_q      <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            key_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            wait_cnt_q    <= wait_cnt_d;
            blk_q         <= blk_d;
            key_q         <= key_d;
            in_ready_q    <= in_ready_d;
            aes_ld_q      <= aes_ld_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            key_err_q     <= key_err_d;
        end
    end

    aes_word_ser u_ser (
        .clk       (clk),
        .rst       (rst),
        .ld        (ser_ld),
        .ld_dat    (aes_text_out),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (ser_done)
    );

    assign in_ready    = in_ready_q;
    assign aes_ld      = aes_ld_q;
    assign aes_key     = key_q;
    assign aes_text_in = blk_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign key_err     = key_err_q;

endmodule
